// File: rtl/sdram_burst_client.sv
// Frame-buffer client between a camera/display pair and a full-page SDRAM burst controller.
// Two 1024x16 FIFOs decouple the pixel streams; an FSM schedules write and read bursts.
module sdram_burst_client #(
    parameter int FRAME_BURSTS = 600,
    parameter int BURST_LEN    = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_pix_valid,
    input  logic [15:0] wr_pix_data,
    input  logic        wr_frame_start,
    input  logic        rd_frame_start,
    input  logic        rd_pix_req,
    output logic [15:0] rd_pix_data,
    output logic        rd_pix_valid,
    output logic        rw,
    output logic        rw_en,
    output logic [14:0] f_addr,
    output logic [15:0] f2s_data,
    input  logic        f2s_data_valid,
    input  logic [15:0] s2f_data,
    input  logic        s2f_data_valid,
    input  logic        ready,
    output logic        wr_overflow,
    output logic        rd_underflow
);

    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int CW    = 11;
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [CW-1:0] BURST_CNT  = CW'(BURST_LEN);
    localparam logic [14:0]   LAST_BURST = 15'(FRAME_BURSTS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    function automatic logic [14:0] next_burst(input logic [14:0] a);
        return (a == LAST_BURST) ? 15'd0 : a + 15'd1;
    endfunction

    // Write FIFO (camera -> controller)
    logic [15:0]   wmem [DEPTH];
    logic [AW-1:0] wwp_q, wrp_q;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          wf_full, wf_empty, wf_push, wf_pop;

    assign wf_full  = (wcnt_q == FULL_CNT);
    assign wf_empty = (wcnt_q == '0);
    assign wf_push  = wr_pix_valid && !wf_full;
    assign wf_pop   = f2s_data_valid && !wf_empty;
    assign f2s_data = wf_empty ? 16'd0 : wmem[wrp_q];

    always_comb begin
        wcnt_d = wcnt_q;
        if (wf_push && !wf_pop)
            wcnt_d = wcnt_q + 11'd1;
        else if (!wf_push && wf_pop)
            wcnt_d = wcnt_q - 11'd1;
    end

    always_ff @(posedge clk) begin
        if (wf_push)
            wmem[wwp_q] <= wr_pix_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wwp_q  <= '0;
            wrp_q  <= '0;
            wcnt_q <= '0;
        end else begin
            if (wf_push) wwp_q <= wwp_q + 10'd1;
            if (wf_pop)  wrp_q <= wrp_q + 10'd1;
            wcnt_q <= wcnt_d;
        end
    end

    // Read FIFO (controller -> display), registered pop port
    logic [15:0]   rmem [DEPTH];
    logic [AW-1:0] rwp_q, rrp_q;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic          rf_full, rf_empty, rf_push, rf_pop;
    logic [15:0]   rd_pix_data_q;
    logic          rd_pix_valid_q, rd_underflow_q;

    assign rf_full  = (rcnt_q == FULL_CNT);
    assign rf_empty = (rcnt_q == '0);
    assign rf_push  = s2f_data_valid && !rf_full;
    assign rf_pop   = rd_pix_req && !rf_empty;

    always_comb begin
        rcnt_d = rcnt_q;
        if (rf_push && !rf_pop)
            rcnt_d = rcnt_q + 11'd1;
        else if (!rf_push && rf_pop)
            rcnt_d = rcnt_q - 11'd1;
    end

    always_ff @(posedge clk) begin
        if (rf_push)
            rmem[rwp_q] <= s2f_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rwp_q          <= '0;
            rrp_q          <= '0;
            rcnt_q         <= '0;
            rd_pix_data_q  <= '0;
            rd_pix_valid_q <= 1'b0;
            rd_underflow_q <= 1'b0;
        end else begin
            if (rf_push) rwp_q <= rwp_q + 10'd1;
            if (rf_pop) begin
                rrp_q         <= rrp_q + 10'd1;
                rd_pix_data_q <= rmem[rrp_q];
            end
            rcnt_q         <= rcnt_d;
            rd_pix_valid_q <= rf_pop;
            if (rd_pix_req && rf_empty)
                rd_underflow_q <= 1'b1;
        end
    end

    assign rd_pix_data  = rd_pix_data_q;
    assign rd_pix_valid = rd_pix_valid_q;
    assign rd_underflow = rd_underflow_q;

    // Burst scheduler
    state_t        state_q;
    logic          rw_q, rw_en_q, rd_active_q, wr_restart_q, rd_restart_q, wr_overflow_q;
    logic [14:0]   f_addr_q, wr_baddr_q, rd_baddr_q;
    logic [CW-1:0] xfer_q, xfer_d;
    logic          wr_elig, rd_elig, xfer_now;

    assign wr_elig  = (wcnt_q >= BURST_CNT);
    assign rd_elig  = (rcnt_q <= BURST_CNT);
    // Writes count words actually drawn from the FIFO so an underrun shows up as a short burst
    assign xfer_now = rw_q ? s2f_data_valid : wf_pop;
    assign xfer_d   = xfer_q + CW'(xfer_now);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rw_q          <= 1'b0;
            rw_en_q       <= 1'b0;
            f_addr_q      <= '0;
            wr_baddr_q    <= '0;
            rd_baddr_q    <= '0;
            rd_active_q   <= 1'b0;
            wr_restart_q  <= 1'b0;
            rd_restart_q  <= 1'b0;
            xfer_q        <= '0;
            wr_overflow_q <= 1'b0;
        end else begin
            rw_en_q <= 1'b0;
            if (wr_pix_valid && wf_full)
                wr_overflow_q <= 1'b1;
            if (state_q != IDLE) begin
                if (wr_frame_start) wr_restart_q <= 1'b1;
                if (rd_frame_start) rd_restart_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    xfer_q <= '0;
                    if (wr_frame_start)
                        wr_baddr_q <= '0;
                    if (rd_frame_start) begin
                        rd_baddr_q  <= '0;
                        rd_active_q <= 1'b1;
                    end
                    if (ready && wr_elig) begin
                        state_q  <= ISSUE;
                        rw_q     <= 1'b0;
                        rw_en_q  <= 1'b1;
                        f_addr_q <= wr_frame_start ? 15'd0 : wr_baddr_q;
                    end else if (ready && (rd_active_q || rd_frame_start) && rd_elig) begin
                        state_q  <= ISSUE;
                        rw_q     <= 1'b1;
                        rw_en_q  <= 1'b1;
                        f_addr_q <= rd_frame_start ? 15'd0 : rd_baddr_q;
                    end
                end
                ISSUE: begin
                    xfer_q  <= xfer_d;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    xfer_q <= xfer_d;
                    if (!ready)
                        state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    xfer_q <= xfer_d;
                    if (ready) begin
                        state_q <= IDLE;
                        // A pending or coincident frame start overrides the increment
                        if (wr_frame_start || wr_restart_q)
                            wr_baddr_q <= '0;
                        else if (!rw_q)
                            wr_baddr_q <= next_burst(wr_baddr_q);
                        if (rd_frame_start || rd_restart_q) begin
                            rd_baddr_q  <= '0;
                            rd_active_q <= 1'b1;
                        end else if (rw_q) begin
                            rd_baddr_q <= next_burst(rd_baddr_q);
                        end
                        wr_restart_q <= 1'b0;
                        rd_restart_q <= 1'b0;
                        if (!rw_q && xfer_d != BURST_CNT)
                            wr_overflow_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rw          = rw_q;
    assign rw_en       = rw_en_q;
    assign f_addr      = f_addr_q;
    assign wr_overflow = wr_overflow_q;

endmodule

// File: tb/tb_sdram_burst_client.sv
// Scoreboard bench for sdram_burst_client: queues hold pixels/words in push order and are
// compared against f2s_data and rd_pix_data as the design delivers them.
module tb_sdram_burst_client;

    logic        clk;
    logic        rst;
    logic        wr_pix_valid;
    logic [15:0] wr_pix_data;
    logic        wr_frame_start;
    logic        rd_frame_start;
    logic        rd_pix_req;
    logic [15:0] rd_pix_data;
    logic        rd_pix_valid;
    logic        rw;
    logic        rw_en;
    logic [14:0] f_addr;
    logic [15:0] f2s_data;
    logic        f2s_data_valid;
    logic [15:0] s2f_data;
    logic        s2f_data_valid;
    logic        ready;
    logic        wr_overflow;
    logic        rd_underflow;

    int errors = 0;
    int checks = 0;
    logic [15:0] wr_q[$];
    logic [15:0] rd_q[$];

    sdram_burst_client #(.FRAME_BURSTS(4), .BURST_LEN(512)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_pix_valid   (wr_pix_valid),
        .wr_pix_data    (wr_pix_data),
        .wr_frame_start (wr_frame_start),
        .rd_frame_start (rd_frame_start),
        .rd_pix_req     (rd_pix_req),
        .rd_pix_data    (rd_pix_data),
        .rd_pix_valid   (rd_pix_valid),
        .rw             (rw),
        .rw_en          (rw_en),
        .f_addr         (f_addr),
        .f2s_data       (f2s_data),
        .f2s_data_valid (f2s_data_valid),
        .s2f_data       (s2f_data),
        .s2f_data_valid (s2f_data_valid),
        .ready          (ready),
        .wr_overflow    (wr_overflow),
        .rd_underflow   (rd_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pixels(input int n);
        logic [15:0] d;
        for (int i = 0; i < n; i++) begin
            d = 16'($urandom);
            wr_pix_data  = d;
            wr_pix_valid = 1'b1;
            if (wr_q.size() < 1024)
                wr_q.push_back(d);
            tick();
        end
        wr_pix_valid = 1'b0;
    endtask

    task automatic wait_rw_en();
        for (int i = 0; i < 20 && !rw_en; i++)
            tick();
        check_eq("rw_en_seen", rw_en, 1);
    endtask

    task automatic do_write_burst(input logic [14:0] exp_addr, input bit pulse_wfs);
        logic [15:0] e;
        ready = 1'b1;
        wait_rw_en();
        check_eq("wr_rw", rw, 0);
        check_eq("wr_f_addr", f_addr, exp_addr);
        ready = 1'b0;
        tick();
        check_eq("wr_rw_en_one_cycle", rw_en, 0);
        for (int i = 0; i < 512; i++) begin
            e = (wr_q.size() != 0) ? wr_q.pop_front() : 16'd0;
            check_eq("f2s_data", f2s_data, e);
            f2s_data_valid = 1'b1;
            if (pulse_wfs && i == 100)
                wr_frame_start = 1'b1;
            tick();
            wr_frame_start = 1'b0;
        end
        f2s_data_valid = 1'b0;
        check_eq("wr_rw_stable", rw, 0);
        check_eq("wr_f_addr_stable", f_addr, exp_addr);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
    endtask

    task automatic do_read_burst(input logic [14:0] exp_addr);
        logic [15:0] d;
        ready = 1'b1;
        wait_rw_en();
        check_eq("rd_rw", rw, 1);
        check_eq("rd_f_addr", f_addr, exp_addr);
        ready = 1'b0;
        tick();
        check_eq("rd_rw_en_one_cycle", rw_en, 0);
        for (int i = 0; i < 512; i++) begin
            d = 16'($urandom);
            s2f_data       = d;
            s2f_data_valid = 1'b1;
            rd_q.push_back(d);
            tick();
        end
        s2f_data_valid = 1'b0;
        check_eq("rd_f_addr_stable", f_addr, exp_addr);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
    endtask

    task automatic pop_reads(input int n);
        logic [15:0] e;
        rd_pix_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            e = (rd_q.size() != 0) ? rd_q.pop_front() : 16'd0;
            check_eq("rd_pix_valid", rd_pix_valid, 1);
            check_eq("rd_pix_data", rd_pix_data, e);
        end
        rd_pix_req = 1'b0;
        tick();
        check_eq("rd_pix_valid_idle", rd_pix_valid, 0);
    endtask

    initial begin
        logic [15:0] last_rd;
        rst = 1'b1;
        wr_pix_valid = 1'b0;
        wr_pix_data = '0;
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
        rd_pix_req = 1'b0;
        f2s_data_valid = 1'b0;
        s2f_data = '0;
        s2f_data_valid = 1'b0;
        ready = 1'b0;
        tick();
        tick();
        check_eq("rst_rw_en", rw_en, 0);
        check_eq("rst_rw", rw, 0);
        check_eq("rst_f_addr", f_addr, 0);
        check_eq("rst_rd_pix_valid", rd_pix_valid, 0);
        check_eq("rst_rd_pix_data", rd_pix_data, 0);
        check_eq("rst_wr_overflow", wr_overflow, 0);
        check_eq("rst_rd_underflow", rd_underflow, 0);
        check_eq("rst_f2s_data", f2s_data, 0);
        rst = 1'b0;
        tick();

        // Basic write bursts, address wrap at 4, deferred frame restart
        ready = 1'b1;
        push_pixels(512);
        do_write_burst(15'd0, 1'b0);
        check_eq("wr_overflow_full_burst", wr_overflow, 0);
        check_eq("f2s_empty_zero", f2s_data, 0);
        push_pixels(512);
        do_write_burst(15'd1, 1'b0);
        push_pixels(512);
        do_write_burst(15'd2, 1'b0);
        push_pixels(512);
        do_write_burst(15'd3, 1'b0);
        push_pixels(512);
        do_write_burst(15'd0, 1'b0);
        push_pixels(512);
        do_write_burst(15'd1, 1'b1);
        push_pixels(512);
        do_write_burst(15'd0, 1'b0);

        // Display read burst and in-order pops
        rd_frame_start = 1'b1;
        tick();
        rd_frame_start = 1'b0;
        do_read_burst(15'd0);
        pop_reads(512);
        last_rd = rd_pix_data;
        rd_pix_req = 1'b1;
        tick();
        rd_pix_req = 1'b0;
        check_eq("underflow_valid", rd_pix_valid, 0);
        check_eq("underflow_data_held", rd_pix_data, last_rd);
        check_eq("rd_underflow", rd_underflow, 1);

        // Write and read both eligible: write goes first
        push_pixels(512);
        do_write_burst(15'd1, 1'b0);
        do_read_burst(15'd1);
        pop_reads(512);

        // Write FIFO overflow: 1025th pixel dropped
        check_eq("wr_overflow_pre", wr_overflow, 0);
        push_pixels(1025);
        check_eq("wr_overflow_set", wr_overflow, 1);
        do_write_burst(15'd2, 1'b0);
        do_write_burst(15'd3, 1'b0);
        check_eq("ovf_fifo_drained", f2s_data, 0);

        // Reset in the middle of a write burst
        push_pixels(512);
        ready = 1'b1;
        wait_rw_en();
        check_eq("rst_burst_f_addr", f_addr, 0);
        ready = 1'b0;
        tick();
        f2s_data_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_eq("f2s_data_pre_rst", f2s_data, wr_q.pop_front());
            tick();
        end
        f2s_data_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wr_q.delete();
        check_eq("abort_rw_en", rw_en, 0);
        check_eq("abort_rw", rw, 0);
        check_eq("abort_f_addr", f_addr, 0);
        check_eq("abort_wr_overflow", wr_overflow, 0);
        check_eq("abort_rd_underflow", rd_underflow, 0);
        check_eq("abort_rd_pix_valid", rd_pix_valid, 0);
        check_eq("abort_f2s_empty", f2s_data, 0);
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("abort_no_request", rw_en, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
